// File: rtl/vga_write_scheduler.sv
// vga_write_scheduler
// Owns the single write port of the 16x12 video RAM. Each cycle it chooses one
// write: a CPU single-cell write always wins that cycle. Otherwise the
// rectangle-fill engine writes the next cell of a clipped rectangle, walking it
// in row-major order. Every output is registered, so a write chosen in one cycle
// is presented for exactly one cycle after the next edge.
module vga_write_scheduler #(
    parameter int DATA_WIDTH = 3,
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_WIDTH  = 16,
    parameter int MEM_HEIGHT = 12
) (
    input  logic                  Clock,
    input  logic                  Reset,
    // CPU single-cell write
    input  logic                  iCpuReq,
    input  logic [ADDR_WIDTH-1:0] iCpuAddr,
    input  logic [DATA_WIDTH-1:0] iCpuData,
    output logic                  oCpuAck,
    // Rectangle fill command
    input  logic                  iFillStart,
    input  logic [3:0]            iFillX0,
    input  logic [3:0]            iFillY0,
    input  logic [4:0]            iFillW,
    input  logic [4:0]            iFillH,
    input  logic [DATA_WIDTH-1:0] iFillColor,
    output logic                  oFillBusy,
    output logic                  oFillDone,
    output logic                  oFillError,
    // Video RAM write port
    output logic                  oWriteEnable,
    output logic [ADDR_WIDTH-1:0] oWriteAddress,
    output logic [DATA_WIDTH-1:0] oWriteData
);

    // Screen coordinates are held one bit wider than the 4-bit command fields so
    // that screen dimensions and clipped extents fit without overflow.
    localparam int CW = 5;

    localparam logic [CW-1:0]       SCREEN_W = CW'(MEM_WIDTH);
    localparam logic [CW-1:0]       SCREEN_H = CW'(MEM_HEIGHT);
    localparam logic [ADDR_WIDTH:0] NUM_CELLS = (ADDR_WIDTH + 1)'(MEM_WIDTH * MEM_HEIGHT);
    localparam logic [ADDR_WIDTH-1:0] ROW_STRIDE = ADDR_WIDTH'(MEM_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Latched fill parameters and the row-major cursor.
    logic [CW-1:0]         x0_q, x0_d;
    logic [CW-1:0]         x_last_q, x_last_d;
    logic [CW-1:0]         y_last_q, y_last_d;
    logic [CW-1:0]         x_q, x_d;
    logic [CW-1:0]         y_q, y_d;
    logic [DATA_WIDTH-1:0] color_q, color_d;

    // Registered outputs.
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  ack_q, ack_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    // Command decode helpers.
    logic [CW-1:0]         start_x0;
    logic [CW-1:0]         start_y0;
    logic [CW-1:0]         avail_w;
    logic [CW-1:0]         avail_h;
    logic [CW-1:0]         clip_w;
    logic [CW-1:0]         clip_h;
    logic                  origin_bad;
    logic                  extent_zero;
    logic                  cpu_addr_ok;
    logic [ADDR_WIDTH-1:0] fill_addr;

    // Origin check, clipping against the screen edges and the cursor address.
    always_comb begin
        start_x0    = {1'b0, iFillX0};
        start_y0    = {1'b0, iFillY0};
        origin_bad  = (start_x0 >= SCREEN_W) || (start_y0 >= SCREEN_H);
        extent_zero = (iFillW == '0) || (iFillH == '0);
        // Only meaningful when the origin is on screen, so these never underflow.
        avail_w     = SCREEN_W - start_x0;
        avail_h     = SCREEN_H - start_y0;
        clip_w      = (iFillW < avail_w) ? iFillW : avail_w;
        clip_h      = (iFillH < avail_h) ? iFillH : avail_h;
        cpu_addr_ok = ({1'b0, iCpuAddr} < NUM_CELLS);
        fill_addr   = ADDR_WIDTH'(y_q) * ROW_STRIDE + ADDR_WIDTH'(x_q);
    end

    // Next-state, arbitration and next-output decisions.
    always_comb begin
        state_d   = state_q;
        x0_d      = x0_q;
        x_last_d  = x_last_q;
        y_last_d  = y_last_q;
        x_d       = x_q;
        y_d       = y_q;
        color_d   = color_q;

        wr_en_d   = 1'b0;
        wr_addr_d = '0;
        wr_data_d = '0;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        // Busy and done follow the state one cycle later so they line up with
        // the writes that state produced.
        busy_d    = (state_q == FILL);
        done_d    = (state_q == DONE);

        // The CPU owns the port whenever it asks; out-of-range addresses are
        // acknowledged but never reach the RAM.
        if (iCpuReq) begin
            ack_d = 1'b1;
            if (cpu_addr_ok) begin
                wr_en_d   = 1'b1;
                wr_addr_d = iCpuAddr;
                wr_data_d = iCpuData;
            end
        end

        case (state_q)
            IDLE: begin
                if (iFillStart) begin
                    if (origin_bad) begin
                        err_d = 1'b1;
                    end else if (extent_zero) begin
                        state_d = DONE;
                    end else begin
                        x0_d     = start_x0;
                        x_d      = start_x0;
                        y_d      = start_y0;
                        x_last_d = start_x0 + clip_w - CW'(1);
                        y_last_d = start_y0 + clip_h - CW'(1);
                        color_d  = iFillColor;
                        state_d  = FILL;
                    end
                end
            end

            FILL: begin
                // A CPU request this cycle stalls the cursor in place.
                if (!iCpuReq) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = fill_addr;
                    wr_data_d = color_q;
                    if (x_q == x_last_q) begin
                        x_d = x0_q;
                        if (y_q == y_last_q) begin
                            state_d = DONE;
                        end else begin
                            y_d = y_q + CW'(1);
                        end
                    end else begin
                        x_d = x_q + CW'(1);
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, fill parameters and output registers with synchronous reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= IDLE;
            x0_q      <= '0;
            x_last_q  <= '0;
            y_last_q  <= '0;
            x_q       <= '0;
            y_q       <= '0;
            color_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            x0_q      <= x0_d;
            x_last_q  <= x_last_d;
            y_last_q  <= y_last_d;
            x_q       <= x_d;
            y_q       <= y_d;
            color_q   <= color_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign oWriteEnable  = wr_en_q;
    assign oWriteAddress = wr_addr_q;
    assign oWriteData    = wr_data_q;
    assign oCpuAck       = ack_q;
    assign oFillBusy     = busy_q;
    assign oFillDone     = done_q;
    assign oFillError    = err_q;

endmodule

// File: tb/tb_vga_write_scheduler.sv
// Scoreboard bench for vga_write_scheduler: stimulus pushes the expected output
// events (with the cycle they must appear in); a monitor pops and compares.
module tb_vga_write_scheduler;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       iCpuReq;
    logic [7:0] iCpuAddr;
    logic [2:0] iCpuData;
    logic       oCpuAck;
    logic       iFillStart;
    logic [3:0] iFillX0;
    logic [3:0] iFillY0;
    logic [4:0] iFillW;
    logic [4:0] iFillH;
    logic [2:0] iFillColor;
    logic       oFillBusy;
    logic       oFillDone;
    logic       oFillError;
    logic       oWriteEnable;
    logic [7:0] oWriteAddress;
    logic [2:0] oWriteData;

    vga_write_scheduler dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .iCpuReq      (iCpuReq),
        .iCpuAddr     (iCpuAddr),
        .iCpuData     (iCpuData),
        .oCpuAck      (oCpuAck),
        .iFillStart   (iFillStart),
        .iFillX0      (iFillX0),
        .iFillY0      (iFillY0),
        .iFillW       (iFillW),
        .iFillH       (iFillH),
        .iFillColor   (iFillColor),
        .oFillBusy    (oFillBusy),
        .oFillDone    (oFillDone),
        .oFillError   (oFillError),
        .oWriteEnable (oWriteEnable),
        .oWriteAddress(oWriteAddress),
        .oWriteData   (oWriteData)
    );

    always #5 Clock = ~Clock;

    // Edge counter: after posedge k, cyc == k.
    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    // Event kinds
    localparam int EV_WR   = 0;
    localparam int EV_DONE = 1;
    localparam int EV_ERR  = 2;
    localparam int EV_ACK  = 3;  // acknowledged but dropped CPU write

    typedef struct {
        int kind;
        int addr;
        int data;
        int busy;
        int ack;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    function automatic void push(int kind, int addr, int data, int busy, int ack, int c);
        ev_t e;
        e.kind = kind; e.addr = addr; e.data = data;
        e.busy = busy; e.ack = ack; e.cyc = c;
        exp_q.push_back(e);
    endfunction

    // Expected writes of an uninterrupted fill accepted at edge e, then done.
    function automatic void push_fill(int e, int x0, int y0, int we, int he, int col);
        int k = 0;
        for (int y = y0; y < y0 + he; y++) begin
            for (int x = x0; x < x0 + we; x++) begin
                push(EV_WR, y * 16 + x, col, 1, 0, e + 1 + k);
                k++;
            end
        end
        push(EV_DONE, 0, 0, 0, 0, e + 1 + k);
    endfunction

    task automatic observe(int kind, int addr, int data, int busy, int ack);
        ev_t e;
        bit  ok;
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL unexpected_event: got kind=%0d addr=%0d data=%0d busy=%0d ack=%0d cyc=%0d, required none",
                     kind, addr, data, busy, ack, cyc);
        end else begin
            e  = exp_q.pop_front();
            ok = (e.kind == kind) && (e.cyc == cyc) && (e.busy == busy) && (e.ack == ack) &&
                 ((kind != EV_WR) || ((e.addr == addr) && (e.data == data)));
            if (ok) begin
                n_pass++;
                $display("ok   event kind=%0d addr=%0d data=%0d busy=%0d ack=%0d cyc=%0d",
                         kind, addr, data, busy, ack, cyc);
            end else begin
                $display("FAIL event: got kind=%0d addr=%0d data=%0d busy=%0d ack=%0d cyc=%0d, required kind=%0d addr=%0d data=%0d busy=%0d ack=%0d cyc=%0d",
                         kind, addr, data, busy, ack, cyc,
                         e.kind, e.addr, e.data, e.busy, e.ack, e.cyc);
            end
        end
    endtask

    // Monitor: every presented output becomes an observed event.
    always @(negedge Clock) begin
        if (oWriteEnable)
            observe(EV_WR, int'(oWriteAddress), int'(oWriteData), int'(oFillBusy), int'(oCpuAck));
        else if (oCpuAck)
            observe(EV_ACK, 0, 0, int'(oFillBusy), 1);
        if (oFillDone)
            observe(EV_DONE, 0, 0, int'(oFillBusy), int'(oCpuAck));
        if (oFillError)
            observe(EV_ERR, 0, 0, int'(oFillBusy), int'(oCpuAck));
    end

    task automatic check(string name, int act, int req);
        n_checks++;
        if (act == req) begin
            n_pass++;
            $display("ok   %s = %0d", name, act);
        end else begin
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic check_outputs_zero(string tag);
        check({tag, "_we"},   int'(oWriteEnable), 0);
        check({tag, "_addr"}, int'(oWriteAddress), 0);
        check({tag, "_data"}, int'(oWriteData), 0);
        check({tag, "_ack"},  int'(oCpuAck), 0);
        check({tag, "_busy"}, int'(oFillBusy), 0);
        check({tag, "_done"}, int'(oFillDone), 0);
        check({tag, "_err"},  int'(oFillError), 0);
    endtask

    // Advance until just after edge c (inputs set now are sampled at edge c+1).
    task automatic go(int c);
        while (cyc < c) begin
            @(posedge Clock);
            #1;
        end
    endtask

    // Pulse iFillStart; e returns the edge that sampled it.
    task automatic start_fill(int x0, int y0, int w, int h, int col, output int e);
        iFillStart = 1'b1;
        iFillX0 = 4'(x0); iFillY0 = 4'(y0);
        iFillW = 5'(w);   iFillH = 5'(h);
        iFillColor = 3'(col);
        e = cyc + 1;
        @(posedge Clock);
        #1;
        iFillStart = 1'b0;
    endtask

    task automatic cpu_write(int addr, int data, output int e);
        iCpuReq = 1'b1;
        iCpuAddr = 8'(addr);
        iCpuData = 3'(data);
        e = cyc + 1;
        @(posedge Clock);
        #1;
        iCpuReq = 1'b0;
    endtask

    initial begin
        int e;
        int e2;
        Reset = 1'b1;
        iCpuReq = 1'b0; iCpuAddr = '0; iCpuData = '0;
        iFillStart = 1'b0; iFillX0 = '0; iFillY0 = '0;
        iFillW = '0; iFillH = '0; iFillColor = '0;
        go(3);
        check_outputs_zero("reset");
        Reset = 1'b0;
        go(5);

        // 1. Basic fill 2,1,3,2 colour 5: 18,19,20,34,35,36 then done.
        push_fill(cyc + 1, 2, 1, 3, 2, 5);
        start_fill(2, 1, 3, 2, 5, e);
        go(e + 10);

        // 2. CPU write stalls the third fill write.
        e = cyc + 1;
        push(EV_WR, 18, 5, 1, 0, e + 1);
        push(EV_WR, 19, 5, 1, 0, e + 2);
        push(EV_WR, 100, 2, 1, 1, e + 3);
        push(EV_WR, 20, 5, 1, 0, e + 4);
        push(EV_WR, 34, 5, 1, 0, e + 5);
        push(EV_WR, 35, 5, 1, 0, e + 6);
        push(EV_WR, 36, 5, 1, 0, e + 7);
        push(EV_DONE, 0, 0, 0, 0, e + 8);
        start_fill(2, 1, 3, 2, 5, e);
        go(e + 2);
        cpu_write(100, 2, e2);
        go(e + 12);

        // 3. Clipping at bottom-right corner: 190, 191 then done.
        push_fill(cyc + 1, 14, 11, 2, 1, 7);
        start_fill(14, 11, 5, 3, 7, e);
        go(e + 6);

        // 4a. Zero width: done only.
        push(EV_DONE, 0, 0, 0, 0, cyc + 2);
        start_fill(3, 3, 0, 4, 1, e);
        go(e + 5);
        // 4b. Origin row off-screen: error only, no writes, no done.
        push(EV_ERR, 0, 0, 0, 0, cyc + 1);
        start_fill(0, 12, 2, 2, 4, e);
        go(e + 5);
        // 4c. FSM back in IDLE: a follow-up fill runs normally.
        push_fill(cyc + 1, 5, 0, 1, 1, 3);
        start_fill(5, 0, 1, 1, 3, e);
        go(e + 5);

        // 5. Reset after the second write aborts the fill.
        e = cyc + 1;
        push(EV_WR, 18, 6, 1, 0, e + 1);
        push(EV_WR, 19, 6, 1, 0, e + 2);
        start_fill(2, 1, 3, 2, 6, e);
        go(e + 2);
        Reset = 1'b1;
        go(e + 3);
        check_outputs_zero("abort");
        Reset = 1'b0;
        go(e + 6);
        push_fill(cyc + 1, 0, 0, 1, 1, 4);
        start_fill(0, 0, 1, 1, 4, e);
        go(e + 5);

        // 6a. Start pulse mid-fill is ignored.
        push_fill(cyc + 1, 2, 1, 3, 2, 1);
        start_fill(2, 1, 3, 2, 1, e);
        go(e + 2);
        start_fill(0, 0, 1, 1, 6, e2);
        go(e + 10);
        // 6b. CPU write to address 200: acknowledged, dropped.
        push(EV_ACK, 0, 0, 0, 1, cyc + 1);
        cpu_write(200, 3, e);
        go(e + 3);
        // 6c. Valid CPU write while idle.
        push(EV_WR, 77, 6, 0, 1, cyc + 1);
        cpu_write(77, 6, e);
        go(e + 3);

        // 7. CPU write and fill start together in IDLE.
        e = cyc + 1;
        push(EV_WR, 5, 1, 0, 1, e);
        push_fill(e, 0, 0, 2, 1, 3);
        iCpuReq = 1'b1; iCpuAddr = 8'd5; iCpuData = 3'd1;
        start_fill(0, 0, 2, 1, 3, e);
        iCpuReq = 1'b0;
        go(e + 10);

        check("events_outstanding", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
